decode_stage: RTL and testbench

- Registered RV32I/RV64I instruction-decode stage between fetch and execute, replacing the single-cycle combinational decoder.
- Accepts {inst, pc} over valid/ready, decodes fields, immediate and ALU/jump controls, and presents them one cycle later through an output register with an optional skid buffer.
- Reports ebreak as a sticky halt output instead of a DPI call.

---
 rtl/decode_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage
//   Registered RV32I/RV64I decode stage sitting between fetch and execute.
//   An instruction {in_inst, in_pc} accepted over valid/ready is decoded
//   combinationally and captured into an output register; it is presented
//   one cycle after acceptance. With EN_SKID=1 a second entry (skid) lets
//   in_ready be independent of out_ready. An accepted ebreak raises a
//   sticky halt that only reset clears.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               drop output and skid entries (branch redirect)
//   in_valid/in_ready   fetch handshake; in_inst, in_pc are the payload
//   out_valid/out_ready execute handshake
//   out_pc              pc of the presented entry
//   out_rs1/rs2/rd      register fields inst[19:15]/[24:20]/[11:7]
//   out_imm             sign-extended immediate (XLEN bits)
//   out_src1_sel        0 rs1, 1 pc, 2 zero
//   out_src2_sel        0 imm, 1 const 4, 2 rs2
//   out_jump            0 jal, 1 jalr, 2 none, 3 branch
//   out_wen             rd write enable
//   out_ebreak          entry is exactly 32'h00100073
//   out_illegal         unsupported opcode or SYSTEM encoding
//   halt                sticky, set when an ebreak is accepted

module decode_stage #(
  parameter int XLEN    = 32,
  parameter bit EN_SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_src1_sel,
  output logic [1:0]      out_src2_sel,
  output logic [1:0]      out_jump,
  output logic            out_wen,
  output logic            out_ebreak,
  output logic            out_illegal,
  output logic            halt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  localparam logic [1:0] SRC1_RS1  = 2'd0;
  localparam logic [1:0] SRC1_PC   = 2'd1;
  localparam logic [1:0] SRC1_ZERO = 2'd2;
  localparam logic [1:0] SRC2_IMM  = 2'd0;
  localparam logic [1:0] SRC2_FOUR = 2'd1;
  localparam logic [1:0] SRC2_RS2  = 2'd2;
  localparam logic [1:0] JMP_JAL   = 2'd0;
  localparam logic [1:0] JMP_JALR  = 2'd1;
  localparam logic [1:0] JMP_NONE  = 2'd2;
  localparam logic [1:0] JMP_BR    = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [1:0]      src1_sel;
    logic [1:0]      src2_sel;
    logic [1:0]      jump;
    logic            wen;
    logic            ebreak;
    logic            illegal;
  } entry_t;

  // Every immediate is first assembled as a 32-bit value, then widened.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  entry_t w_dec;
  entry_t r_out;
  entry_t r_skid;
  logic   r_out_valid;
  logic   r_skid_valid;
  logic   r_halt;
  logic   w_in_ready;
  logic   w_accept;
  logic   w_out_free;

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
  assign w_imm_u = {in_inst[31:12], 12'h000};
  assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};

  // Combinational decode of the instruction currently offered by fetch.
  always_comb begin
    w_dec          = '0;
    w_dec.pc       = in_pc;
    w_dec.rs1      = in_inst[19:15];
    w_dec.rs2      = in_inst[24:20];
    w_dec.rd       = in_inst[11:7];
    w_dec.src1_sel = SRC1_RS1;
    w_dec.src2_sel = SRC2_IMM;
    w_dec.jump     = JMP_NONE;
    case (in_inst[6:0])
      OPC_LUI: begin
        w_dec.imm = sext32(w_imm_u); w_dec.src1_sel = SRC1_ZERO; w_dec.wen = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.imm = sext32(w_imm_u); w_dec.src1_sel = SRC1_PC; w_dec.wen = 1'b1;
      end
      OPC_JAL: begin
        w_dec.imm = sext32(w_imm_j); w_dec.src1_sel = SRC1_PC;
        w_dec.src2_sel = SRC2_FOUR; w_dec.jump = JMP_JAL; w_dec.wen = 1'b1;
      end
      OPC_JALR: begin
        w_dec.imm = sext32(w_imm_i); w_dec.src1_sel = SRC1_PC;
        w_dec.src2_sel = SRC2_FOUR; w_dec.jump = JMP_JALR; w_dec.wen = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD: begin
        w_dec.imm = sext32(w_imm_i); w_dec.wen = 1'b1;
      end
      OPC_OP: begin
        w_dec.src2_sel = SRC2_RS2; w_dec.wen = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.imm = sext32(w_imm_b); w_dec.src2_sel = SRC2_RS2; w_dec.jump = JMP_BR;
      end
      OPC_STORE: begin
        w_dec.imm = sext32(w_imm_s);
      end
      OPC_SYSTEM: begin
        // Only the exact ebreak encoding is supported; ecall/csr are illegal.
        if (in_inst == INST_EBREAK) begin
          w_dec.ebreak = 1'b1;
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  // Output slot frees up when empty or being consumed (a flush cycle is handled separately).
  assign w_out_free = !r_out_valid || out_ready;

  // Input readiness; held low during reset, halt and flush.
  always_comb begin
    w_in_ready = 1'b0;
    if (!rst_n || r_halt || flush) begin
      w_in_ready = 1'b0;
    end else if (EN_SKID) begin
      w_in_ready = !r_skid_valid;
    end else begin
      w_in_ready = w_out_free;
    end
  end

  assign w_accept = in_valid && w_in_ready;

  // Valid flags and sticky halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_halt       <= 1'b0;
    end else begin
      if (w_accept && w_dec.ebreak) begin
        r_halt <= 1'b1;
      end
      if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_out_free) begin
        // The skid entry is older than anything fetch offers, so it goes first.
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
        end else begin
          r_out_valid <= w_accept;
        end
      end else if (w_accept) begin
        r_skid_valid <= 1'b1;
      end
    end
  end

  // Payload registers; they only change when loaded so fields hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out <= r_skid;
        end else if (w_accept) begin
          r_out <= w_dec;
        end
      end else if (w_accept) begin
        r_skid <= w_dec;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_pc       = r_out.pc;
  assign out_rs1      = r_out.rs1;
  assign out_rs2      = r_out.rs2;
  assign out_rd       = r_out.rd;
  assign out_imm      = r_out.imm;
  assign out_src1_sel = r_out.src1_sel;
  assign out_src2_sel = r_out.src2_sel;
  assign out_jump     = r_out.jump;
  assign out_wen      = r_out.wen;
  assign out_ebreak   = r_out.ebreak;
  assign out_illegal  = r_out.illegal;
  assign halt         = r_halt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 64-bit skid-buffered instance checked
// through an expected-entry queue, plus a 32-bit single-slice instance.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [63:0] out_imm;
  logic [1:0]  out_src1_sel, out_src2_sel, out_jump;
  logic        out_wen, out_ebreak, out_illegal, halt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_inst, b_in_pc, b_out_pc, b_out_imm;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
  logic [1:0]  b_out_src1_sel, b_out_src2_sel, b_out_jump;
  logic        b_out_wen, b_out_ebreak, b_out_illegal, b_halt;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [1:0]  src1;
    logic [1:0]  src2;
    logic [1:0]  jump;
    logic        wen;
    logic        ebreak;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  exp_t got;
  int   checks;
  int   errors;

  decode_stage #(.XLEN(64), .EN_SKID(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_src1_sel(out_src1_sel), .out_src2_sel(out_src2_sel), .out_jump(out_jump),
    .out_wen(out_wen), .out_ebreak(out_ebreak), .out_illegal(out_illegal), .halt(halt)
  );

  decode_stage #(.XLEN(32), .EN_SKID(1'b0)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_imm(b_out_imm),
    .out_src1_sel(b_out_src1_sel), .out_src2_sel(b_out_src2_sel), .out_jump(b_out_jump),
    .out_wen(b_out_wen), .out_ebreak(b_out_ebreak), .out_illegal(b_out_illegal), .halt(b_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [63:0] imm, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [1:0] j, input logic wen,
                              input logic eb, input logic ill);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.src1 = s1; e.src2 = s2; e.jump = j; e.wen = wen; e.ebreak = eb; e.illegal = ill;
    return e;
  endfunction

  task automatic send(input logic [31:0] inst, input logic [63:0] pc, input exp_t e);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; cur_exp = e;
  endtask

  // One clock: score the handshakes seen before the edge, then step to the next negedge.
  task automatic tick();
    #1;
    if (flush) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      got = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_src1_sel, out_src2_sel,
             out_jump, out_wen, out_ebreak, out_illegal};
      if (sb.size() == 0) begin
        chk("sb_underflow", 160'(1), 160'(0));
      end else begin
        chk("entry", 160'(got), 160'(sb.pop_front()));
      end
    end
    if (in_valid && in_ready) sb.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 64'h0;
    out_ready = 1'b0; cur_exp = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_inst = 32'h0; b_in_pc = 32'h0; b_out_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_in_ready", 160'(in_ready), 160'(0));
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_halt", 160'(halt), 160'(0));
    chk("rst_fields", 160'({out_pc, out_imm, out_rd, out_jump, out_wen}), 160'(0));
    @(negedge clk); rst_n = 1'b1;

    // 32-bit single-slice instance.
    b_in_valid = 1'b1; b_in_inst = 32'hfff00093; b_in_pc = 32'h80000000; b_out_ready = 1'b1;
    #1; chk("b_in_ready_idle", 160'(b_in_ready), 160'(1));
    @(posedge clk); @(negedge clk); b_out_ready = 1'b0; b_in_inst = 32'h00000013;
    #1;
    chk("b_out_valid", 160'(b_out_valid), 160'(1));
    chk("b_addi_imm", 160'(b_out_imm), 160'(32'hffffffff));
    chk("b_addi_pc", 160'(b_out_pc), 160'(32'h80000000));
    chk("b_addi_ctl", 160'({b_out_rd, b_out_rs1, b_out_src1_sel, b_out_src2_sel, b_out_jump, b_out_wen}),
        160'({5'd1, 5'd0, 2'd0, 2'd0, 2'd2, 1'b1}));
    chk("b_in_ready_blocked", 160'(b_in_ready), 160'(0));
    b_out_ready = 1'b1; #1;
    chk("b_in_ready_drain", 160'(b_in_ready), 160'(1));
    b_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);

    // Decode stream through the 64-bit skid instance, out_ready held high.
    out_ready = 1'b1;
    send(32'hfff00093, 64'h80000000, mk(64'h80000000, 5'd1, 5'd0, 5'd31, 64'hffffffffffffffff, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0)); tick();
    send(32'h001000ef, 64'h80000004, mk(64'h80000004, 5'd1, 5'd0, 5'd1, 64'h0000000000000800, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0)); tick();
    send(32'hfe208ee3, 64'h80000008, mk(64'h80000008, 5'd29, 5'd1, 5'd2, 64'hfffffffffffffffc, 2'd0, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0)); tick();
    send(32'h800002b7, 64'h8000000c, mk(64'h8000000c, 5'd5, 5'd0, 5'd0, 64'hffffffff80000000, 2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0)); tick();
    send(32'h12345197, 64'h80000010, mk(64'h80000010, 5'd3, 5'd8, 5'd3, 64'h0000000012345000, 2'd1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0)); tick();
    send(32'h00008067, 64'h80000014, mk(64'h80000014, 5'd0, 5'd1, 5'd0, 64'h0, 2'd1, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0)); tick();
    send(32'h002081b3, 64'h80000018, mk(64'h80000018, 5'd3, 5'd1, 5'd2, 64'h0, 2'd0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0)); tick();
    send(32'hff812203, 64'h8000001c, mk(64'h8000001c, 5'd4, 5'd2, 5'd24, 64'hfffffffffffffff8, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0)); tick();
    send(32'h00512623, 64'h80000020, mk(64'h80000020, 5'd12, 5'd2, 5'd5, 64'h000000000000000c, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0)); tick();
    send(32'h0000007f, 64'h80000024, mk(64'h80000024, 5'd0, 5'd0, 5'd0, 64'h0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1)); tick();
    send(32'h00000073, 64'h80000028, mk(64'h80000028, 5'd0, 5'd0, 5'd0, 64'h0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1)); tick();
    in_valid = 1'b0; tick();
    chk("stream_drained", 160'(sb.size()), 160'(0));

    // Skid: three offers with out_ready low; the third must be refused.
    out_ready = 1'b0;
    send(32'h00100093, 64'h100, mk(64'h100, 5'd1, 5'd0, 5'd1, 64'h1, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
    #1; chk("skid_rdy1", 160'(in_ready), 160'(1)); tick();
    send(32'h00200113, 64'h104, mk(64'h104, 5'd2, 5'd0, 5'd2, 64'h2, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
    #1; chk("skid_rdy2", 160'(in_ready), 160'(1)); tick();
    send(32'h00300193, 64'h108, mk(64'h108, 5'd3, 5'd0, 5'd3, 64'h3, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
    #1; chk("skid_rdy3", 160'(in_ready), 160'(0)); tick();
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("skid_moved_out", 160'({out_valid, in_ready}), 160'({1'b1, 1'b1}));
    tick(); tick();
    chk("skid_drained", 160'({out_valid, 32'(sb.size())}), 160'(0));

    // Flush with output and skid both occupied.
    out_ready = 1'b0;
    send(32'h00400213, 64'h200, mk(64'h200, 5'd4, 5'd0, 5'd4, 64'h4, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0)); tick();
    send(32'h00500293, 64'h204, mk(64'h204, 5'd5, 5'd0, 5'd5, 64'h5, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0)); tick();
    send(32'h00600313, 64'h208, mk(64'h208, 5'd6, 5'd0, 5'd6, 64'h6, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
    flush = 1'b1; out_ready = 1'b1;
    #1; chk("flush_in_ready", 160'(in_ready), 160'(0)); tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_out_valid", 160'(out_valid), 160'(0));
    chk("flush_skid_empty", 160'(in_ready), 160'(1));
    chk("flush_fields_hold", 160'(out_pc), 160'(64'h200));
    tick(); chk("flush_no_skid_leak", 160'(out_valid), 160'(0));

    // ebreak: flows out, sets sticky halt, blocks input; flush keeps halt.
    send(32'h00100073, 64'h300, mk(64'h300, 5'd0, 5'd0, 5'd1, 64'h0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0)); tick();
    send(32'h00700393, 64'h304, mk(64'h304, 5'd7, 5'd0, 5'd7, 64'h7, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
    #1;
    chk("halt_set", 160'({halt, in_ready, out_valid}), 160'({1'b1, 1'b0, 1'b1}));
    tick();
    in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0; #1;
    chk("halt_after_flush", 160'({halt, in_ready}), 160'({1'b1, 1'b0}));
    chk("halt_drained", 160'(sb.size()), 160'(0));
    rst_n = 1'b0; #1;
    chk("halt_reset", 160'({halt, in_ready}), 160'(0));
    @(negedge clk); rst_n = 1'b1; sb.delete();

    // Asynchronous reset while entries are held.
    out_ready = 1'b0;
    send(32'h00800413, 64'h400, mk(64'h400, 5'd8, 5'd0, 5'd8, 64'h8, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0)); tick();
    send(32'h00900493, 64'h404, mk(64'h404, 5'd9, 5'd0, 5'd9, 64'h9, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0)); tick();
    in_valid = 1'b0;
    #2; rst_n = 1'b0; #1;
    chk("midrst_out_valid", 160'({out_valid, in_ready}), 160'(0));
    chk("midrst_fields", 160'({out_pc, out_imm}), 160'(0));
    sb.delete();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    tick(); tick();
    chk("midrst_no_glitch", 160'(out_valid), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
